// File: rtl/btc_host_pkg.sv
// Shared types and sizing helpers for the miner-chip host feeder.
package btc_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_RQ,
        FETCH,
        ACK_HI,
        ACK_LO,
        CAPTURE,
        FINISH
    } state_t;

    typedef enum logic [1:0] {
        STEP_SETTLE,
        STEP_MEM,
        STEP_DATA
    } fetch_step_t;

    localparam int HASH_BYTES = 32;
    localparam int ADDR_W     = 7;
    localparam int IDX_W      = $clog2(HASH_BYTES);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width that holds the largest preload of the shared wait counter.
    function automatic int timer_width(input int a, input int b, input int c,
                                       input int d, input int e, input int f);
        int m;
        m = max2(max2(max2(a, b), max2(c, d)), max2(e, f));
        return $clog2(m + 1);
    endfunction

    localparam int TIMER_W = timer_width(2, 1, 2, 2, 3, 1048576);

endpackage

// File: rtl/btc_sync.sv
// Multi-flop synchronizer for one asynchronous chip-side level.
module btc_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/btc_host_feeder.sv
// Host side of the miner chip byte handshake: serves data bytes from memory,
// then collects the 32-byte result into one 256-bit word.
module btc_host_feeder
    import btc_host_pkg::*;
#(
    parameter int START_CYCLES = 2,
    parameter int MEM_LAT      = 1,
    parameter int SETUP_CYCLES = 2,
    parameter int RDY_HIGH     = 2,
    parameter int RDY_LOW      = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT      = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    output logic              busy,
    output logic [255:0]      hash,
    output logic              hash_valid,
    output logic              timeout_err,
    output logic [7:0]        bytes_served,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              dut_start,
    output logic              dut_rdy,
    output logic [7:0]        dut_data,
    input  logic [7:0]        dut_uo,
    input  logic              dut_rq,
    input  logic              dut_done
);

    localparam int CNT_W = timer_width(START_CYCLES, MEM_LAT, SETUP_CYCLES,
                                       RDY_HIGH, RDY_LOW, TIMEOUT);

    state_t           state, state_nxt;
    fetch_step_t      step, step_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] idx;
    logic             readout;
    logic             rq_s, done_s;

    logic clear_job, load_addr, load_data, store_byte, count_byte;
    logic next_idx, set_readout, set_timeout;

    btc_sync #(.STAGES(SYNC_STAGES)) u_sync_rq (
        .clk(clk), .rst(rst), .d(dut_rq), .q(rq_s)
    );

    btc_sync #(.STAGES(SYNC_STAGES)) u_sync_done (
        .clk(clk), .rst(rst), .d(dut_done), .q(done_s)
    );

    // One down-counter times every wait; each state preloads it on entry
    // and leaves when it reaches zero.
    always_comb begin
        state_nxt   = state;
        step_nxt    = step;
        cnt_nxt     = (cnt == '0) ? '0 : cnt - 1'b1;
        clear_job   = 1'b0;
        load_addr   = 1'b0;
        load_data   = 1'b0;
        store_byte  = 1'b0;
        count_byte  = 1'b0;
        next_idx    = 1'b0;
        set_readout = 1'b0;
        set_timeout = 1'b0;

        case (state)
            IDLE: begin
                if (go) begin
                    clear_job = 1'b1;
                    state_nxt = START;
                    cnt_nxt   = CNT_W'(START_CYCLES - 1);
                end
            end
            START: begin
                if (cnt == '0) begin
                    state_nxt = WAIT_RQ;
                    cnt_nxt   = CNT_W'(TIMEOUT - 1);
                end
            end
            WAIT_RQ: begin
                if (rq_s) begin
                    cnt_nxt = CNT_W'(SETUP_CYCLES - 1);
                    if (done_s) begin
                        set_readout = 1'b1;
                        state_nxt   = CAPTURE;
                    end else begin
                        state_nxt = FETCH;
                        step_nxt  = STEP_SETTLE;
                    end
                end else if (cnt == '0) begin
                    set_timeout = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            FETCH: begin
                if (cnt == '0) begin
                    case (step)
                        STEP_SETTLE: begin
                            load_addr = 1'b1;
                            step_nxt  = STEP_MEM;
                            cnt_nxt   = CNT_W'(MEM_LAT);
                        end
                        STEP_MEM: begin
                            load_data = 1'b1;
                            step_nxt  = STEP_DATA;
                            cnt_nxt   = CNT_W'(SETUP_CYCLES - 1);
                        end
                        default: begin
                            count_byte = 1'b1;
                            state_nxt  = ACK_HI;
                            cnt_nxt    = CNT_W'(RDY_HIGH - 1);
                        end
                    endcase
                end
            end
            CAPTURE: begin
                if (cnt == '0) begin
                    store_byte = 1'b1;
                    state_nxt  = ACK_HI;
                    cnt_nxt    = CNT_W'(RDY_HIGH - 1);
                end
            end
            ACK_HI: begin
                if (cnt == '0) begin
                    state_nxt = ACK_LO;
                    cnt_nxt   = CNT_W'(RDY_LOW - 1);
                end
            end
            ACK_LO: begin
                if (cnt == '0) begin
                    if (readout && idx == IDX_W'(HASH_BYTES - 1)) begin
                        state_nxt = FINISH;
                    end else begin
                        next_idx  = readout;
                        state_nxt = WAIT_RQ;
                        cnt_nxt   = CNT_W'(TIMEOUT - 1);
                    end
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Chip-facing strobes are registered from the next state so they stay glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            step         <= STEP_SETTLE;
            cnt          <= '0;
            idx          <= '0;
            readout      <= 1'b0;
            busy         <= 1'b0;
            hash         <= '0;
            hash_valid   <= 1'b0;
            timeout_err  <= 1'b0;
            bytes_served <= '0;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            dut_start    <= 1'b0;
            dut_rdy      <= 1'b0;
            dut_data     <= '0;
        end else begin
            state      <= state_nxt;
            step       <= step_nxt;
            cnt        <= cnt_nxt;
            busy       <= (state_nxt != IDLE) && (state_nxt != FINISH);
            hash_valid <= (state_nxt == FINISH);
            dut_start  <= (state_nxt == START);
            dut_rdy    <= (state_nxt == ACK_HI);
            mem_rd_en  <= load_addr;

            if (clear_job) begin
                idx          <= '0;
                readout      <= 1'b0;
                timeout_err  <= 1'b0;
                bytes_served <= '0;
                hash         <= '0;
            end
            if (set_timeout) begin
                timeout_err <= 1'b1;
            end
            if (set_readout) begin
                readout <= 1'b1;
            end
            if (next_idx) begin
                idx <= idx + 1'b1;
            end
            if (load_addr) begin
                mem_addr <= dut_uo[ADDR_W-1:0];
            end
            if (load_data) begin
                dut_data <= mem_rdata;
            end
            if (count_byte && bytes_served != 8'hFF) begin
                bytes_served <= bytes_served + 1'b1;
            end
            if (store_byte) begin
                hash[8*(HASH_BYTES - 1 - int'(idx)) +: 8] <= dut_uo;
            end
        end
    end

endmodule

// File: tb/tb_btc_host_feeder.sv
// Self-checking bench: the bench plays the miner chip and the byte memory.
module tb_btc_host_feeder;

    localparam int RDY_HIGH = 2;
    localparam int RDY_LOW  = 3;
    localparam int TIMEOUT  = 100;

    logic         clk = 1'b0;
    logic         rst;
    logic         go;
    logic         busy;
    logic [255:0] hash;
    logic         hash_valid;
    logic         timeout_err;
    logic [7:0]   bytes_served;
    logic         mem_rd_en;
    logic [6:0]   mem_addr;
    logic [7:0]   mem_rdata;
    logic         dut_start;
    logic         dut_rdy;
    logic [7:0]   dut_data;
    logic [7:0]   dut_uo;
    logic         dut_rq;
    logic         dut_done;

    always #5 clk = ~clk;

    btc_host_feeder #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .go(go), .busy(busy), .hash(hash),
        .hash_valid(hash_valid), .timeout_err(timeout_err),
        .bytes_served(bytes_served), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .dut_start(dut_start),
        .dut_rdy(dut_rdy), .dut_data(dut_data), .dut_uo(dut_uo),
        .dut_rq(dut_rq), .dut_done(dut_done)
    );

    // Byte memory with one cycle of read latency.
    logic [7:0] mem [128];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int checks = 0;
    int passes = 0;
    int hv_count = 0;
    always @(negedge clk) if (hash_valid) hv_count++;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] value;
        logic [6:0] exp_addr;
    } vec_t;
    vec_t vecs [6];

    task automatic check_output(input string name, input logic [255:0] actual,
                                input logic [255:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    endtask

    task automatic wait_rdy(input logic level, input string name, output int n);
        n = 0;
        while (dut_rdy !== level && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dut_rdy === level) passes++;
        else $display("[TB] FAIL %s: dut_rdy=%b expected %b within 300 cycles", name, dut_rdy, level);
    endtask

    task automatic wait_hash();
        int n;
        n = 0;
        while (hash_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (hash_valid === 1'b1) passes++;
        else $display("[TB] FAIL hash_valid_wait: hash_valid=%b expected 1 within 300 cycles", hash_valid);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    // One chip request: raise rq with the given uo, capture the byte at the
    // rdy rise, drop rq, and measure how long rdy stays high.
    task automatic apply_stimulus(input logic done_v, input logic [7:0] uo_v,
                                  output logic [7:0] seen, output int high_n);
        int n;
        dut_done = done_v;
        dut_uo   = uo_v;
        dut_rq   = 1'b1;
        wait_rdy(1'b1, "rdy_rise", n);
        seen   = dut_data;
        dut_rq = 1'b0;
        wait_rdy(1'b0, "rdy_fall", high_n);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]   seen;
        logic [255:0] exp_hash;
        int           high_n, n, hv_before, nbytes;
        logic [6:0]   addr;

        vecs[0] = '{8'h05, 8'hA5, 7'h05};
        vecs[1] = '{8'h85, 8'h3C, 7'h05};
        vecs[2] = '{8'h7F, 8'hFF, 7'h7F};
        vecs[3] = '{8'h00, 8'h00, 7'h00};
        vecs[4] = '{8'h2A, 8'h5A, 7'h2A};
        vecs[5] = '{8'hC0, 8'h81, 7'h40};
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);

        rst = 1'b1; go = 1'b0; dut_rq = 1'b0; dut_done = 1'b0; dut_uo = 8'h00;
        repeat (3) @(negedge clk);
        check_output("reset_busy", 256'(busy), 256'(0));
        check_output("reset_hash", hash, 256'(0));
        check_output("reset_rdy", 256'(dut_rdy), 256'(0));
        check_output("reset_bytes", 256'(bytes_served), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        // Data phase from a fixed table, then a counting readout.
        pulse_go();
        check_output("start_high", 256'(dut_start), 256'(1));
        check_output("busy_high", 256'(busy), 256'(1));
        for (int i = 0; i < 6; i++) begin
            mem[vecs[i].exp_addr] = vecs[i].value;
            apply_stimulus(1'b0, vecs[i].uo, seen, high_n);
            check_output($sformatf("vec%0d_data", i), 256'(seen), 256'(vecs[i].value));
            check_output($sformatf("vec%0d_addr", i), 256'(mem_addr), 256'(vecs[i].exp_addr));
            check_output($sformatf("vec%0d_rdy_high", i), 256'(high_n), 256'(RDY_HIGH));
            check_output($sformatf("vec%0d_served", i), 256'(bytes_served), 256'(i + 1));
        end
        hv_before = hv_count;
        for (int b = 0; b < 32; b++) apply_stimulus(1'b1, 8'(b), seen, high_n);
        wait_hash();
        check_output("count_busy", 256'(busy), 256'(0));
        check_output("count_hash", hash,
            256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F);
        @(negedge clk);
        check_output("count_hv_pulses", 256'(hv_count), 256'(hv_before + 1));
        check_output("count_hash_valid_low", 256'(hash_valid), 256'(0));
        check_output("count_served", 256'(bytes_served), 256'(6));
        dut_done = 1'b0;
        repeat (4) @(negedge clk);

        // done rises while a data byte is being acknowledged; go pulsed while busy.
        mem[7'h10] = 8'hC3;
        pulse_go();
        dut_uo = 8'h10; dut_rq = 1'b1;
        wait_rdy(1'b1, "late_rdy_rise", n);
        check_output("late_data", 256'(dut_data), 256'(8'hC3));
        dut_rq = 1'b0; dut_done = 1'b1; dut_uo = 8'hE0;
        wait_rdy(1'b0, "late_rdy_fall", high_n);
        check_output("late_rdy_high", 256'(high_n), 256'(RDY_HIGH));
        dut_rq = 1'b1;
        wait_rdy(1'b1, "late_cap_rise", n);
        check_output("late_low_gap", 256'(n >= RDY_LOW), 256'(1));
        check_output("late_served", 256'(bytes_served), 256'(1));
        dut_rq = 1'b0; go = 1'b1;
        wait_rdy(1'b0, "late_cap_fall", high_n);
        go = 1'b0;
        exp_hash = '0;
        for (int b = 0; b < 32; b++) exp_hash = {exp_hash[247:0], 8'(8'hE0 + b)};
        hv_before = hv_count;
        for (int b = 1; b < 32; b++) apply_stimulus(1'b1, 8'(8'hE0 + b), seen, high_n);
        wait_hash();
        check_output("late_hash", hash, exp_hash);
        @(negedge clk);
        check_output("late_hv_pulses", 256'(hv_count), 256'(hv_before + 1));
        check_output("late_served_end", 256'(bytes_served), 256'(1));
        repeat (4) @(negedge clk);
        check_output("go_ignored_busy", 256'(busy), 256'(0));
        check_output("go_ignored_start", 256'(dut_start), 256'(0));
        dut_done = 1'b0;

        // Randomised job checked against the memory model and a shift-in hash.
        pulse_go();
        nbytes = 8 + int'($urandom_range(0, 12));
        for (int i = 0; i < nbytes; i++) begin
            addr = 7'($urandom);
            apply_stimulus(1'b0, {1'($urandom), addr}, seen, high_n);
            check_output($sformatf("rand%0d_data", i), 256'(seen), 256'(mem[addr]));
        end
        exp_hash = '0;
        hv_before = hv_count;
        for (int b = 0; b < 32; b++) begin
            logic [7:0] r;
            r = 8'($urandom);
            exp_hash = {exp_hash[247:0], r};
            apply_stimulus(1'b1, r, seen, high_n);
        end
        wait_hash();
        check_output("rand_hash", hash, exp_hash);
        @(negedge clk);
        check_output("rand_hv_pulses", 256'(hv_count), 256'(hv_before + 1));
        check_output("rand_served", 256'(bytes_served), 256'(nbytes));
        dut_done = 1'b0;
        repeat (4) @(negedge clk);

        // Watchdog: no request ever arrives.
        hv_before = hv_count;
        pulse_go();
        repeat (95) @(negedge clk);
        check_output("timeout_early", 256'(timeout_err), 256'(0));
        check_output("timeout_early_busy", 256'(busy), 256'(1));
        repeat (15) @(negedge clk);
        check_output("timeout_err", 256'(timeout_err), 256'(1));
        check_output("timeout_busy", 256'(busy), 256'(0));
        check_output("timeout_no_hv", 256'(hv_count), 256'(hv_before));
        pulse_go();
        check_output("timeout_cleared", 256'(timeout_err), 256'(0));
        check_output("timeout_rejob_busy", 256'(busy), 256'(1));

        // Asynchronous reset in the middle of a byte acknowledge.
        mem[7'h03] = 8'h77;
        dut_uo = 8'h03; dut_rq = 1'b1;
        wait_rdy(1'b1, "rst_rdy_rise", n);
        rst = 1'b1;
        #1;
        check_output("rst_rdy", 256'(dut_rdy), 256'(0));
        check_output("rst_start", 256'(dut_start), 256'(0));
        check_output("rst_busy", 256'(busy), 256'(0));
        check_output("rst_rd_en", 256'(mem_rd_en), 256'(0));
        check_output("rst_hash", hash, 256'(0));
        check_output("rst_served", 256'(bytes_served), 256'(0));
        @(negedge clk);
        dut_rq = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
